// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: control word bit positions and MBR controller states.
package cpu_pkg;

  localparam int CS_MBR_RD      = 0;
  localparam int CS_MBR_WR      = 1;
  localparam int CS_MBR_LD_ACC  = 2;
  localparam int CS_MBR_CLR_ERR = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mbr_state_t;

  // True while a memory access is outstanding.
  function automatic logic mbr_is_busy(mbr_state_t s);
    return (s == READ) || (s == WRITE);
  endfunction

endpackage

// File: rtl/mbr_watchdog.sv
// Clearable wait-state counter that flags the final cycle of an unanswered memory access.
module mbr_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Expiry is only meaningful while still waiting: a ready in the last cycle wins.
  assign expire_o = count_i && (timer_q == LAST);

  // Next count: zero outside an access, otherwise one more per unanswered cycle.
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (count_i && !expire_o) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/mbr_ctrl.sv
// Memory buffer register with its memory handshake controller and timeout watchdog.
module mbr_ctrl
  import cpu_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   control_signal,
  input  logic [AW-1:0] MARtoMBR,
  input  logic [DW-1:0] ACCtoMBR,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] MBRtoBR,
  output logic [7:0]    MBRtoIR,
  output logic          busy,
  output logic          done,
  output logic          err
);

  mbr_state_t    state_q, state_d;
  logic [DW-1:0] mbr_q, mbr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic          inAccess;
  logic          expire;
  logic          unused_cs;

  // Only the low four control bits belong to this block.
  assign unused_cs = ^control_signal[31:4];

  assign inAccess = mbr_is_busy(state_q);

  mbr_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!inAccess),
    .count_i  (inAccess && !mem_ready),
    .expire_o (expire)
  );

  // Next-state logic: command decode in IDLE, handshake completion or timeout in an access.
  always_comb begin
    state_d = state_q;
    mbr_d   = mbr_q;
    addr_d  = addr_q;
    err_d   = err_q;

    if (control_signal[CS_MBR_CLR_ERR]) begin
      err_d = 1'b0;
    end
    if (expire) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (control_signal[CS_MBR_RD]) begin
          addr_d  = MARtoMBR;
          state_d = READ;
        end else if (control_signal[CS_MBR_WR]) begin
          addr_d  = MARtoMBR;
          if (control_signal[CS_MBR_LD_ACC]) begin
            mbr_d = ACCtoMBR;
          end
          state_d = WRITE;
        end else if (control_signal[CS_MBR_LD_ACC]) begin
          mbr_d = ACCtoMBR;
        end
      end
      READ: begin
        if (mem_ready) begin
          mbr_d   = mem_rdata;
          state_d = DONE;
        end else if (expire) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        if (mem_ready || expire) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, buffer, address and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mbr_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mbr_q   <= mbr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign mem_en    = inAccess;
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = mbr_q;
  assign MBRtoBR   = mbr_q;
  assign MBRtoIR   = mbr_q[DW-1:DW-8];
  assign busy      = inAccess;
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_mbr_ctrl.sv
// Self-checking bench for mbr_ctrl using a queue of expected access results.
module tb_mbr_ctrl;

  localparam int DW      = 16;
  localparam int AW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   control_signal;
  logic [AW-1:0] MARtoMBR;
  logic [DW-1:0] ACCtoMBR;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] MBRtoBR;
  logic [7:0]    MBRtoIR;
  logic          busy;
  logic          done;
  logic          err;

  mbr_ctrl #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .MARtoMBR       (MARtoMBR),
    .ACCtoMBR       (ACCtoMBR),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .MBRtoBR        (MBRtoBR),
    .MBRtoIR        (MBRtoIR),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          checkWdata;
    logic [DW-1:0] mbr;
    logic          errFlag;
  } exp_t;

  exp_t expQ[$];
  int assertCount = 0;
  int failCount   = 0;

  // Access monitor: records the first cycle of each access and notices any drift during it.
  int            accessCount   = 0;
  int            unstableCount = 0;
  logic          prevEn        = 1'b0;
  logic          seenWe;
  logic [AW-1:0] seenAddr;
  logic [DW-1:0] seenWdata;

  always @(posedge clk) begin
    if (mem_en === 1'b1 && prevEn !== 1'b1) begin
      accessCount <= accessCount + 1;
      seenWe      <= mem_we;
      seenAddr    <= mem_addr;
      seenWdata   <= mem_wdata;
    end else if (mem_en === 1'b1 &&
                 (mem_we !== seenWe || mem_addr !== seenAddr || mem_wdata !== seenWdata)) begin
      unstableCount <= unstableCount + 1;
    end
    prevEn <= mem_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until done is seen or the budget runs out; counts as a comparison.
  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    assertCount++;
    if (done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  // Pops the scoreboard entry for the finished access and compares it against what happened.
  task automatic check_completion(input string name);
    exp_t e;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL %s_scoreboard: queue empty at done", name);
      return;
    end
    e = expQ.pop_front();
    if (seenWe !== e.we || seenAddr !== e.addr || (e.checkWdata && seenWdata !== e.wdata)) begin
      failCount++;
      $display("[TB] FAIL %s_access: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
               name, seenWe, seenAddr, seenWdata, e.we, e.addr, e.wdata);
    end
    assertCount++;
    if (MBRtoBR !== e.mbr || MBRtoIR !== e.mbr[15:8]) begin
      failCount++;
      $display("[TB] FAIL %s_mbr: MBRtoBR=%h MBRtoIR=%h, required %h/%h",
               name, MBRtoBR, MBRtoIR, e.mbr, e.mbr[15:8]);
    end
    assertCount++;
    if (err !== e.errFlag) begin
      failCount++;
      $display("[TB] FAIL %s_err: err=%b, required %b", name, err, e.errFlag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    control_signal = '0;
    MARtoMBR = '0;
    ACCtoMBR = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    assertCount++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, MBRtoBR, MBRtoIR, busy, done, err} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: en=%b we=%b addr=%h wdata=%h br=%h ir=%h busy=%b done=%b err=%b, required all 0",
               mem_en, mem_we, mem_addr, mem_wdata, MBRtoBR, MBRtoIR, busy, done, err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    control_signal = 32'h1;
    MARtoMBR = 8'h12;
    expQ.push_back('{we: 1'b0, addr: 8'h12, wdata: '0, checkWdata: 1'b0, mbr: 16'hA55A, errFlag: 1'b0});
    tick();
    control_signal = '0;
    assertCount++;
    if (busy !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL read_cycle1: busy=%b en=%b we=%b, required 1/1/0", busy, mem_en, mem_we);
    end
    mem_rdata = 16'hA55A;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    assertCount++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL read_cycle2: done=%b busy=%b, required 1/0", done, busy);
    end
    check_completion("read");
    tick();
    assertCount++;
    if (done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL read_done_width: done=%b, required 0", done);
    end
  endtask

  task automatic test_acc_load();
    ACCtoMBR = 16'h5A5A;
    control_signal = 32'h4;
    tick();
    control_signal = '0;
    assertCount++;
    if (MBRtoBR !== 16'h5A5A || busy !== 1'b0 || accessCount != 1) begin
      failCount++;
      $display("[TB] FAIL acc_load: MBRtoBR=%h busy=%b accesses=%0d, required 5a5a/0/1",
               MBRtoBR, busy, accessCount);
    end
  endtask

  task automatic test_write_wait();
    ACCtoMBR = 16'h1234;
    MARtoMBR = 8'h40;
    control_signal = 32'h6;
    expQ.push_back('{we: 1'b1, addr: 8'h40, wdata: 16'h1234, checkWdata: 1'b1, mbr: 16'h1234, errFlag: 1'b0});
    tick();
    control_signal = '0;
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 16'h1234) begin
        failCount++;
        $display("[TB] FAIL write_hold_%0d: en=%b we=%b addr=%h wdata=%h, required 1/1/40/1234",
                 i, mem_en, mem_we, mem_addr, mem_wdata);
      end
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    assertCount++;
    if (done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL write_done: done=%b, required 1", done);
    end
    check_completion("write");
    tick();
  endtask

  task automatic test_timeout();
    int n;
    MARtoMBR = 8'h33;
    control_signal = 32'h1;
    expQ.push_back('{we: 1'b0, addr: 8'h33, wdata: '0, checkWdata: 1'b0, mbr: 16'h1234, errFlag: 1'b1});
    tick();
    control_signal = '0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    assertCount++;
    if (n != TIMEOUT) begin
      failCount++;
      $display("[TB] FAIL timeout_length: %0d cycles in READ, required %0d", n, TIMEOUT);
    end
    wait_done("timeout", 2);
    check_completion("timeout");
    tick();
    assertCount++;
    if (err !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL err_sticky: err=%b, required 1", err);
    end
    control_signal = 32'h8;
    tick();
    control_signal = '0;
    assertCount++;
    if (err !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL err_clear: err=%b, required 0", err);
    end
  endtask

  task automatic test_ready_last_cycle();
    MARtoMBR = 8'h21;
    control_signal = 32'h1;
    expQ.push_back('{we: 1'b0, addr: 8'h21, wdata: '0, checkWdata: 1'b0, mbr: 16'hC3E1, errFlag: 1'b0});
    tick();
    control_signal = '0;
    repeat (TIMEOUT - 1) tick();
    mem_rdata = 16'hC3E1;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    wait_done("ready_last", 1);
    check_completion("ready_last");
    tick();
  endtask

  task automatic test_clear_vs_timeout();
    MARtoMBR = 8'h44;
    control_signal = 32'h1;
    expQ.push_back('{we: 1'b0, addr: 8'h44, wdata: '0, checkWdata: 1'b0, mbr: 16'hC3E1, errFlag: 1'b1});
    tick();
    control_signal = 32'h8;
    repeat (TIMEOUT) tick();
    control_signal = '0;
    wait_done("clr_vs_timeout", 1);
    check_completion("clr_vs_timeout");
    tick();
    control_signal = 32'h8;
    tick();
    control_signal = '0;
  endtask

  task automatic test_back_to_back();
    int startCount;
    startCount = accessCount;
    MARtoMBR = 8'h05;
    control_signal = 32'h3;
    expQ.push_back('{we: 1'b0, addr: 8'h05, wdata: '0, checkWdata: 1'b0, mbr: 16'h7E81, errFlag: 1'b0});
    tick();
    assertCount++;
    if (mem_we !== 1'b0 || mem_addr !== 8'h05) begin
      failCount++;
      $display("[TB] FAIL priority_read: we=%b addr=%h, required 0/05", mem_we, mem_addr);
    end
    tick();
    mem_rdata = 16'h7E81;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    wait_done("priority", 1);
    check_completion("priority");
    tick();
    assertCount++;
    if (busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL cmd_in_done: busy=%b, required 0", busy);
    end
    control_signal = '0;
    tick();
    assertCount++;
    if (accessCount - startCount != 1) begin
      failCount++;
      $display("[TB] FAIL extra_access: %0d accesses, required 1", accessCount - startCount);
    end
  endtask

  task automatic test_reset_mid_access();
    ACCtoMBR = 16'hBEEF;
    MARtoMBR = 8'h77;
    control_signal = 32'h6;
    tick();
    control_signal = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    assertCount++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, MBRtoBR, MBRtoIR, busy, done, err} !== '0) begin
      failCount++;
      $display("[TB] FAIL rst_mid_write: en=%b we=%b addr=%h wdata=%h br=%h busy=%b done=%b, required all 0",
               mem_en, mem_we, mem_addr, mem_wdata, MBRtoBR, busy, done);
    end
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    mem_ready = 1'b0;
    assertCount++;
    if (busy !== 1'b0 || done !== 1'b0 || MBRtoBR !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL ready_after_rst: busy=%b done=%b br=%h, required 0/0/0000", busy, done, MBRtoBR);
    end
    MARtoMBR = 8'h9A;
    control_signal = 32'h1;
    expQ.push_back('{we: 1'b0, addr: 8'h9A, wdata: '0, checkWdata: 1'b0, mbr: 16'h0F0F, errFlag: 1'b0});
    tick();
    control_signal = '0;
    tick();
    tick();
    mem_rdata = 16'h0F0F;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    wait_done("post_rst_read", 1);
    check_completion("post_rst_read");
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_acc_load();
    test_write_wait();
    test_timeout();
    test_ready_last_cycle();
    test_clear_vs_timeout();
    test_back_to_back();
    test_reset_mid_access();
    assertCount++;
    if (unstableCount != 0 || expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL stability: unstable=%0d leftover=%0d, required 0/0", unstableCount, expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mbr_ctrl.md
# mbr_ctrl

Memory buffer register (MBR) with its memory-side handshake controller for the 16-bit CPU datapath. It sits between main memory and the datapath. On control-unit commands it reads a word from memory or writes the current MBR contents to memory, and it drives the MBR word toward the buffer register (BR) and the instruction register (IR). It is the sending end of the MBR→BR path; the BR adds its own register stage downstream.

## Interface
Parameters:
- DW, 16, data width (MBR, memory data, ACC path)
- AW, 8, memory address width
- TIMEOUT, 15, maximum cycles spent waiting for mem_ready before abort (≥1)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- control_signal  in  32  bit0 = read, bit1 = write, bit2 = load MBR from ACC, bit3 = clear err; other bits ignored
- MARtoMBR  in  AW  address from MAR, sampled only when a command is accepted
- ACCtoMBR  in  DW  accumulator data for bit2 loads
- mem_rdata  in  DW  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion strobe
- mem_en  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read (meaningful only with mem_en)
- mem_addr  out  AW  latched access address
- mem_wdata  out  DW  write data (= MBR)
- MBRtoBR  out  DW  MBR contents to BR
- MBRtoIR  out  8  MBR[15:8], opcode field to IR
- busy  out  1  high in READ/WRITE
- done  out  1  one-cycle pulse in DONE
- err  out  1  sticky timeout flag

## Operation
- Reset values: state IDLE, mbr=0, addr=0, timer=0. All outputs 0.
- IDLE, command acceptance:
  - bit0 set: latch addr←MARtoMBR and go to READ. bit0 has priority; a simultaneous bit1 is dropped with no error.
  - bit1 set (bit0 clear): latch addr. If bit2 is also set, mbr←ACCtoMBR in the same edge and the write uses that value. Go to WRITE.
  - bit2 alone: mbr←ACCtoMBR and stay in IDLE.
  - bit3: err←0. Allowed in any state; a timeout in the same cycle wins and sets err.
- READ: mem_en=1, mem_we=0.
  - On an edge with mem_ready=1: mbr←mem_rdata, go to DONE.
- WRITE: mem_en=1, mem_we=1, mem_wdata=mbr.
  - On an edge with mem_ready=1: go to DONE. mbr is unchanged.
- Timeout in READ/WRITE:
  - timer is cleared on entry and increments each cycle without ready.
  - If timer==TIMEOUT-1 and mem_ready=0 at an edge: err←1, mbr unchanged, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Commands in DONE are ignored; the control unit reissues them.
- Commands (bits 0–2) in READ/WRITE/DONE are ignored. mem_ready outside READ/WRITE is ignored.
- MBRtoBR = mbr and MBRtoIR = mbr[15:8], driven straight from the register with no extra stage.

## Timing
- Cycle 0: command seen in IDLE.
- Cycle 1: READ/WRITE, mem_en=1. A zero-wait memory asserts mem_ready here.
- Cycle 2: DONE with done=1. MBRtoBR holds the new read word from this cycle.
- Minimum command-to-done latency: 2 cycles. Each wait state adds 1 cycle.
- Maximum time in READ/WRITE: TIMEOUT cycles.
- mem_addr and mem_wdata are stable for the whole access.
- bit2-only load: MBRtoBR updates the cycle after the command.
- rst mid-access: immediate return to IDLE with all outputs 0. A pending memory ready after reset is ignored.

## Structure
- Shared package cpu_pkg holds:
  - control_signal bit indices: CS_MBR_RD=0, CS_MBR_WR=1, CS_MBR_LD_ACC=2, CS_MBR_CLR_ERR=3.
  - the mbr_state_t enum {IDLE, READ, WRITE, DONE}.
- Timer width is $clog2(TIMEOUT+1).
- One sub-module is natural: mbr_watchdog, the clearable timeout counter with an expire output. All else stays in mbr_ctrl.

## Test plan
- Reset, then read at MARtoMBR=8'h12 with mem_rdata=16'hA55A and ready in cycle 1:
  - done pulses in cycle 2.
  - MBRtoBR=16'hA55A and MBRtoIR=8'hA5.
  - busy is high for 1 cycle.
- ACCtoMBR=16'h1234 with bit1|bit2, addr 8'h40, ready after 3 wait cycles:
  - mem_we=1, mem_addr=8'h40, mem_wdata=16'h1234 held for 4 cycles.
  - done follows.
- Read with mem_ready never asserted (TIMEOUT=15):
  - exactly 15 cycles in READ, then err=1 and done pulses.
  - mbr keeps its prior value.
  - A later bit3 clears err.
- Simultaneous bit0|bit1 at addr 8'h05:
  - read occurs (mem_we=0) and no write is issued.
  - Commands asserted during busy/DONE produce no extra access.
- rst asserted during WRITE wait:
  - all outputs are 0 immediately.
  - A subsequent mem_ready is ignored.
  - A new read completes normally.
